// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle core control FSM; MULTICYCLE_PERF_COUNTERS_EN adds cycle/instruction counters
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       instrOpcode,
    input  logic             branchTaken,
    input  logic             memReady,
    output logic             memReq,
    output logic             memWe,
    output logic             memAddrSel,
    output logic             irWrite,
    output logic             pcWrite,
    output logic [1:0]       pcSrc,
    output logic [1:0]       aluOp,
    output logic             aluUseImm,
    output logic             regWrite,
    output logic [1:0]       wbSel,
    output logic             instrRetired,
    output logic             halt
`ifdef MULTICYCLE_PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0] cycleCount,
    output logic [CNT_W-1:0] instrCount
`endif
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    typedef enum logic [2:0] {CL_R, CL_I, CL_LOAD, CL_STORE, CL_BR, CL_JAL, CL_JALR, CL_LUI} iclass_t;

    state_t  state, nextState;
    iclass_t iclass, decClass;
    logic    decLegal;

    always_comb begin
        decLegal = 1'b1;
        decClass = CL_R;
        case (instrOpcode)
            7'b0110011: decClass = CL_R;
            7'b0010011: decClass = CL_I;
            7'b0000011: decClass = CL_LOAD;
            7'b0100011: decClass = CL_STORE;
            7'b1100011: decClass = CL_BR;
            7'b1101111: decClass = CL_JAL;
            7'b1100111: decClass = CL_JALR;
            7'b0110111: decClass = CL_LUI;
            default:    decLegal = 1'b0;
        endcase
    end

    // The class is captured once in DECODE so later states do not depend on the opcode staying stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FETCH;
            iclass <= CL_R;
        end else begin
            state <= nextState;
            if (state == DECODE) iclass <= decClass;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            FETCH:  if (memReady) nextState = DECODE;
            DECODE: nextState = decLegal ? EXEC : HALT;
            EXEC: begin
                case (iclass)
                    CL_BR:             nextState = FETCH;
                    CL_LOAD, CL_STORE: nextState = MEM;
                    default:           nextState = WB;
                endcase
            end
            MEM:    if (memReady) nextState = (iclass == CL_STORE) ? FETCH : WB;
            WB:     nextState = FETCH;
            HALT:   nextState = HALT;
            default: nextState = FETCH;
        endcase
    end

    // Outputs stay low throughout reset, even with a memory request pending.
    always_comb begin
        memReq       = 1'b0;
        memWe        = 1'b0;
        memAddrSel   = 1'b0;
        irWrite      = 1'b0;
        pcWrite      = 1'b0;
        pcSrc        = 2'd0;
        aluOp        = 2'b00;
        aluUseImm    = 1'b0;
        regWrite     = 1'b0;
        wbSel        = 2'd0;
        instrRetired = 1'b0;
        halt         = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    memReq  = 1'b1;
                    irWrite = memReady;
                end
                EXEC: begin
                    case (iclass)
                        CL_R:              begin aluOp = 2'b10; aluUseImm = 1'b0; end
                        CL_I, CL_JALR:     begin aluOp = 2'b11; aluUseImm = 1'b1; end
                        CL_LOAD, CL_STORE: begin aluOp = 2'b00; aluUseImm = 1'b1; end
                        CL_BR:             begin aluOp = 2'b01; aluUseImm = 1'b0; end
                        default:           begin aluOp = 2'b00; aluUseImm = 1'b0; end
                    endcase
                    if (iclass == CL_BR) begin
                        pcWrite      = 1'b1;
                        pcSrc        = branchTaken ? 2'd1 : 2'd0;
                        instrRetired = 1'b1;
                    end
                end
                MEM: begin
                    memReq     = 1'b1;
                    memAddrSel = 1'b1;
                    memWe      = (iclass == CL_STORE);
                    if (memReady && iclass == CL_STORE) begin
                        pcWrite      = 1'b1;
                        instrRetired = 1'b1;
                    end
                end
                WB: begin
                    regWrite     = 1'b1;
                    pcWrite      = 1'b1;
                    instrRetired = 1'b1;
                    case (iclass)
                        CL_LOAD:          wbSel = 2'd1;
                        CL_JAL, CL_JALR:  wbSel = 2'd2;
                        CL_LUI:           wbSel = 2'd3;
                        default:          wbSel = 2'd0;
                    endcase
                    if (iclass == CL_JAL)       pcSrc = 2'd1;
                    else if (iclass == CL_JALR) pcSrc = 2'd2;
                end
                HALT:    halt = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MULTICYCLE_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycleCount <= '0;
            instrCount <= '0;
        end else begin
            if (state != HALT) cycleCount <= cycleCount + CNT_W'(1);
            if (instrRetired)  instrCount <= instrCount + CNT_W'(1);
        end
    end
`endif

endmodule
